// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared sizes, opcode classes and entry layout for the issue scoreboard
package scoreboard_pkg;

    localparam int SB_SIZE     = 8;
    localparam int SB_SIZE_WID = $clog2(SB_SIZE);
    localparam int CNT_WID     = $clog2(SB_SIZE + 1);
    localparam int ALU_MAX     = 6;
    localparam int LS_MAX      = 4;
    localparam int NREG        = 32;
    localparam int REG_WID     = $clog2(NREG);
    localparam int OPT_WID     = 3;
    localparam int FUNCT3_WID  = 3;
    localparam int XLEN        = 32;

    typedef enum logic [OPT_WID-1:0] {
        OPT_ALU_R  = 3'd0,
        OPT_ALU_I  = 3'd1,
        OPT_LUI    = 3'd2,
        OPT_BRANCH = 3'd3,
        OPT_LOAD   = 3'd4,
        OPT_STORE  = 3'd5
    } opt_e;

    typedef struct packed {
        logic [OPT_WID-1:0]    opt;
        logic [FUNCT3_WID-1:0] funct;
        logic [REG_WID-1:0]    rs1;
        logic [REG_WID-1:0]    rs2;
        logic [REG_WID-1:0]    rd;
        logic [XLEN-1:0]       imm;
    } sb_entry_t;

    function automatic logic is_ls(input logic [OPT_WID-1:0] opt);
        return (opt == OPT_LOAD) || (opt == OPT_STORE);
    endfunction

    function automatic logic has_rd(input logic [OPT_WID-1:0] opt);
        return (opt == OPT_ALU_R) || (opt == OPT_ALU_I) || (opt == OPT_LUI) || (opt == OPT_LOAD);
    endfunction

    function automatic logic uses_rs1(input logic [OPT_WID-1:0] opt);
        return opt != OPT_LUI;
    endfunction

    function automatic logic uses_rs2(input logic [OPT_WID-1:0] opt);
        return (opt == OPT_ALU_R) || (opt == OPT_BRANCH) || (opt == OPT_STORE);
    endfunction

endpackage

// File: rtl/sb_reg_status.sv
// rtl/sb_reg_status.sv - per-register pending-write table with write-back bypassed busy lookups
module sb_reg_status
    import scoreboard_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [REG_WID-1:0]     set_idx,
    input  logic [SB_SIZE_WID-1:0] set_pos,
    input  logic                   clr_en,
    input  logic [REG_WID-1:0]     clr_idx,
    input  logic [SB_SIZE_WID-1:0] clr_pos,
    input  logic [REG_WID-1:0]     rs1_idx,
    input  logic [REG_WID-1:0]     rs2_idx,
    input  logic [REG_WID-1:0]     rd_idx,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   rd_busy
);

    logic [NREG-1:0]        busy_q, busy_d, busy_eff;
    logic [SB_SIZE_WID-1:0] pos_q [NREG];
    logic [SB_SIZE_WID-1:0] pos_d [NREG];

    // A same-cycle issue to the register being written back keeps it busy.
    always_comb begin
        busy_d = busy_q;
        pos_d  = pos_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
            pos_d[set_idx]  = set_pos;
        end
    end

    always_comb begin
        busy_eff = busy_q;
        if (clr_en) busy_eff[clr_idx] = 1'b0;
        rs1_busy = busy_eff[rs1_idx];
        rs2_busy = busy_eff[rs2_idx];
        rd_busy  = busy_eff[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) pos_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            pos_q  <= pos_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && clr_en && busy_q[clr_idx])
            assert (clr_pos == pos_q[clr_idx]) else $error("write-back tag does not match pending writer");
    end

endmodule

// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - in-order issue queue with RAW/WAW hazard check between i_buffer and ALU/LS
module scoreboard
    import scoreboard_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ib_vacant_ALU,
    output logic                   ib_vacant_LS,
    input  logic                   ib_valid,
    input  logic [OPT_WID-1:0]     ib_opt,
    input  logic [FUNCT3_WID-1:0]  ib_funct,
    input  logic [REG_WID-1:0]     ib_rs1,
    input  logic [REG_WID-1:0]     ib_rs2,
    input  logic [REG_WID-1:0]     ib_rd,
    input  logic [XLEN-1:0]        ib_imm,
    input  logic                   alu_ready,
    input  logic                   ls_ready,
    output logic                   alu_valid,
    output logic                   ls_valid,
    output logic [OPT_WID-1:0]     iss_opt,
    output logic [FUNCT3_WID-1:0]  iss_funct,
    output logic [REG_WID-1:0]     iss_rs1,
    output logic [REG_WID-1:0]     iss_rs2,
    output logic [REG_WID-1:0]     iss_rd,
    output logic [XLEN-1:0]        iss_imm,
    output logic [SB_SIZE_WID-1:0] iss_pos,
    input  logic                   wb_valid,
    input  logic [SB_SIZE_WID-1:0] wb_pos,
    input  logic [REG_WID-1:0]     wb_rd
);

    sb_entry_t              entry_q [SB_SIZE];
    sb_entry_t              entry_d [SB_SIZE];
    logic [SB_SIZE_WID-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_WID-1:0]     count_q, count_d, alu_cnt_q, alu_cnt_d, ls_cnt_q, ls_cnt_d;

    sb_entry_t head_e;
    logic      head_ls, in_ls, raw, waw, can_issue, fire, accept;
    logic      rs1_busy, rs2_busy, rd_busy;

    sb_reg_status u_reg_status (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fire && has_rd(head_e.opt)),
        .set_idx  (head_e.rd),
        .set_pos  (head_q),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .clr_pos  (wb_pos),
        .rs1_idx  (head_e.rs1),
        .rs2_idx  (head_e.rs2),
        .rd_idx   (head_e.rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    // Vacancy looks only at registered state so an issue never frees a slot early.
    always_comb begin
        head_e        = entry_q[head_q];
        head_ls       = is_ls(head_e.opt);
        in_ls         = is_ls(ib_opt);
        ib_vacant_ALU = (count_q < CNT_WID'(SB_SIZE)) && (alu_cnt_q < CNT_WID'(ALU_MAX));
        ib_vacant_LS  = (count_q < CNT_WID'(SB_SIZE)) && (ls_cnt_q < CNT_WID'(LS_MAX));
        accept        = ib_valid && (in_ls ? ib_vacant_LS : ib_vacant_ALU);
        raw           = (uses_rs1(head_e.opt) && rs1_busy) || (uses_rs2(head_e.opt) && rs2_busy);
        waw           = has_rd(head_e.opt) && rd_busy;
        can_issue     = (count_q != '0) && !raw && !waw;
        alu_valid     = can_issue && !head_ls;
        ls_valid      = can_issue && head_ls;
        fire          = (alu_valid && alu_ready) || (ls_valid && ls_ready);
        iss_pos       = head_q;
        iss_opt       = '0;
        iss_funct     = '0;
        iss_rs1       = '0;
        iss_rs2       = '0;
        iss_rd        = '0;
        iss_imm       = '0;
        if (count_q != '0) begin
            iss_opt   = head_e.opt;
            iss_funct = head_e.funct;
            iss_rs1   = head_e.rs1;
            iss_rs2   = head_e.rs2;
            iss_rd    = head_e.rd;
            iss_imm   = head_e.imm;
        end
    end

    always_comb begin
        entry_d = entry_q;
        tail_d  = tail_q;
        head_d  = head_q;
        if (accept) begin
            entry_d[tail_q] = {ib_opt, ib_funct, ib_rs1, ib_rs2, ib_rd, ib_imm};
            tail_d          = tail_q + SB_SIZE_WID'(1);
        end
        if (fire) head_d = head_q + SB_SIZE_WID'(1);
        count_d   = count_q + CNT_WID'(accept) - CNT_WID'(fire);
        alu_cnt_d = alu_cnt_q + CNT_WID'(accept && !in_ls) - CNT_WID'(fire && !head_ls);
        ls_cnt_d  = ls_cnt_q + CNT_WID'(accept && in_ls) - CNT_WID'(fire && head_ls);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            alu_cnt_q <= '0;
            ls_cnt_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            alu_cnt_q <= alu_cnt_d;
            ls_cnt_q  <= ls_cnt_d;
        end
    end

    // Entry storage needs no reset: the issue bus is gated by count.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_scoreboard.sv
// tb/tb_scoreboard.sv - queue-based self-checking bench for the issue scoreboard
module tb_scoreboard;
    import scoreboard_pkg::*;

    typedef logic [SB_SIZE_WID+1+OPT_WID+FUNCT3_WID+3*REG_WID+XLEN-1:0] rec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   ib_vacant_ALU, ib_vacant_LS;
    logic                   ib_valid = 1'b0;
    logic [OPT_WID-1:0]     ib_opt = '0;
    logic [FUNCT3_WID-1:0]  ib_funct = '0;
    logic [REG_WID-1:0]     ib_rs1 = '0, ib_rs2 = '0, ib_rd = '0;
    logic [XLEN-1:0]        ib_imm = '0;
    logic                   alu_ready = 1'b0, ls_ready = 1'b0;
    logic                   alu_valid, ls_valid;
    logic [OPT_WID-1:0]     iss_opt;
    logic [FUNCT3_WID-1:0]  iss_funct;
    logic [REG_WID-1:0]     iss_rs1, iss_rs2, iss_rd;
    logic [XLEN-1:0]        iss_imm;
    logic [SB_SIZE_WID-1:0] iss_pos;
    logic                   wb_valid = 1'b0;
    logic [SB_SIZE_WID-1:0] wb_pos = '0;
    logic [REG_WID-1:0]     wb_rd = '0;

    int                     n_checks = 0;
    int                     n_fail = 0;
    int                     max_count = 0;
    logic                   toggle_en = 1'b0;
    logic [SB_SIZE_WID-1:0] tb_tail = '0;
    rec_t                   exp_q[$];

    scoreboard dut (
        .clk(clk), .rst(rst),
        .ib_vacant_ALU(ib_vacant_ALU), .ib_vacant_LS(ib_vacant_LS),
        .ib_valid(ib_valid), .ib_opt(ib_opt), .ib_funct(ib_funct),
        .ib_rs1(ib_rs1), .ib_rs2(ib_rs2), .ib_rd(ib_rd), .ib_imm(ib_imm),
        .alu_ready(alu_ready), .ls_ready(ls_ready),
        .alu_valid(alu_valid), .ls_valid(ls_valid),
        .iss_opt(iss_opt), .iss_funct(iss_funct), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_imm(iss_imm), .iss_pos(iss_pos),
        .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) alu_ready = ~alu_ready;
    endtask

    // ls is the hand-assigned unit for this opcode (1 = LS, 0 = ALU).
    task automatic push(input logic ls, input opt_e o, input logic [REG_WID-1:0] rd,
                        input logic [REG_WID-1:0] rs1, input logic [REG_WID-1:0] rs2,
                        input logic [XLEN-1:0] imm);
        int guard = 0;
        while (!(ls ? ib_vacant_LS : ib_vacant_ALU) && guard < 64) begin
            tick();
            guard++;
        end
        if (guard == 64) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_vacancy: got vacancy 0 expected 1 within 64 cycles");
        end
        ib_opt   = o;
        ib_funct = imm[2:0];
        ib_rd    = rd;
        ib_rs1   = rs1;
        ib_rs2   = rs2;
        ib_imm   = imm;
        ib_valid = 1'b1;
        exp_q.push_back({tb_tail, ls, o, imm[2:0], rd, rs1, rs2, imm});
        tb_tail++;
        tick();
        ib_valid = 1'b0;
    endtask

    task automatic wb(input logic [REG_WID-1:0] rd, input logic [SB_SIZE_WID-1:0] pos);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_pos   = pos;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every handshake pops the oldest expected issue and compares the bus.
    always @(negedge clk) begin
        rec_t act, e;
        if (rst) begin
            if (int'(dut.count_q) > max_count) max_count = int'(dut.count_q);
            if ((alu_valid && alu_ready) || (ls_valid && ls_ready)) begin
                act = {iss_pos, ls_valid, iss_opt, iss_funct, iss_rd, iss_rs1, iss_rs2, iss_imm};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL issue_unexpected: got issue %0h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL issue_bus: got %0h expected %0h", act, e);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("reset_vac_alu", 64'(ib_vacant_ALU), 64'd1);
        chk("reset_vac_ls", 64'(ib_vacant_LS), 64'd1);
        chk("reset_alu_valid", 64'(alu_valid), 64'd0);
        chk("reset_ls_valid", 64'(ls_valid), 64'd0);
        chk("reset_iss_bus", {iss_imm, 16'(iss_rd), 8'(iss_pos)}, 64'd0);

        // Independent ALU ops issue back to back at tags 0,1,2.
        alu_ready = 1'b1;
        tick();
        push(1'b0, OPT_ALU_I, 5'd1, 5'd0, 5'd0, 32'h11);
        push(1'b0, OPT_ALU_I, 5'd2, 5'd0, 5'd0, 32'h12);
        @(negedge clk);
        chk("b2b_alu_valid", 64'(alu_valid), 64'd1);
        push(1'b0, OPT_ALU_I, 5'd3, 5'd0, 5'd0, 32'h13);
        tick();
        wb(5'd1, 3'd0);
        wb(5'd2, 3'd1);
        wb(5'd3, 3'd2);

        // RAW stall released in the write-back cycle.
        push(1'b0, OPT_ALU_I, 5'd5, 5'd0, 5'd0, 32'h25);
        push(1'b0, OPT_ALU_I, 5'd6, 5'd5, 5'd0, 32'h26);
        @(negedge clk);
        chk("raw_stall_0", 64'(alu_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("raw_stall_1", 64'(alu_valid), 64'd0);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_pos = 3'd3;
        @(negedge clk);
        chk("raw_bypass", 64'(alu_valid), 64'd1);
        tick();
        wb_valid = 1'b0;
        wb(5'd6, 3'd4);
        wait_drain("drain_raw");

        // Class limits and full queue.
        alu_ready = 1'b0;
        ls_ready  = 1'b0;
        for (int i = 0; i < 6; i++)
            push(1'b0, OPT_ALU_I, REG_WID'(11 + i), 5'd0, 5'd0, 32'(32'h30 + i));
        @(negedge clk);
        chk("alu_max_vac_alu", 64'(ib_vacant_ALU), 64'd0);
        chk("alu_max_vac_ls", 64'(ib_vacant_LS), 64'd1);
        push(1'b1, OPT_STORE, 5'd0, 5'd0, 5'd0, 32'h40);
        push(1'b1, OPT_STORE, 5'd0, 5'd0, 5'd0, 32'h41);
        @(negedge clk);
        chk("full_vac_alu", 64'(ib_vacant_ALU), 64'd0);
        chk("full_vac_ls", 64'(ib_vacant_LS), 64'd0);
        tick();
        alu_ready = 1'b1;
        ib_opt = OPT_STORE; ib_rd = '0; ib_rs1 = '0; ib_rs2 = '0; ib_imm = 32'hdead;
        ib_valid = 1'b1;
        @(negedge clk);
        chk("full_issue_valid", 64'(alu_valid), 64'd1);
        chk("full_issue_vac_ls", 64'(ib_vacant_LS), 64'd0);
        tick();
        ib_valid = 1'b0;
        @(negedge clk);
        chk("after_issue_vac_alu", 64'(ib_vacant_ALU), 64'd1);
        chk("after_issue_vac_ls", 64'(ib_vacant_LS), 64'd1);
        ls_ready = 1'b1;
        wait_drain("drain_full");
        wb(5'd11, 3'd5);
        wb(5'd12, 3'd6);
        wb(5'd13, 3'd7);
        wb(5'd14, 3'd0);
        wb(5'd15, 3'd1);
        wb(5'd16, 3'd2);

        // WAW behind an in-flight load, and in-order blocking of a younger ALU op.
        push(1'b1, OPT_LOAD, 5'd4, 5'd0, 5'd0, 32'h50);
        push(1'b0, OPT_ALU_I, 5'd4, 5'd0, 5'd0, 32'h51);
        push(1'b0, OPT_ALU_I, 5'd7, 5'd0, 5'd0, 32'h52);
        @(negedge clk);
        chk("waw_stall", 64'(alu_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("in_order_hold", 64'(alu_valid), 64'd0);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd4; wb_pos = 3'd5;
        @(negedge clk);
        chk("waw_release", 64'(alu_valid), 64'd1);
        chk("waw_release_rd", 64'(iss_rd), 64'd4);
        tick();
        wb_valid = 1'b0;
        wait_drain("drain_waw");
        wb(5'd4, 3'd6);
        wb(5'd7, 3'd7);

        // Twenty ops through a ready line that toggles every cycle; tags wrap.
        toggle_en = 1'b1;
        for (int i = 0; i < 20; i++)
            push(1'b0, OPT_BRANCH, 5'd0, 5'd0, 5'd0, 32'(32'h100 + 3 * i));
        wait_drain("drain_wrap");
        toggle_en = 1'b0;
        chk("count_bound", 64'(max_count <= 8), 64'd1);

        // Reset with queued entries and a pending register.
        alu_ready = 1'b1;
        push(1'b0, OPT_ALU_I, 5'd9, 5'd0, 5'd0, 32'h60);
        tick();
        alu_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(1'b0, OPT_BRANCH, 5'd0, 5'd0, 5'd0, 32'(32'h70 + i));
        rst = 1'b0;
        exp_q.delete();
        tb_tail = '0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_count", 64'(dut.count_q), 64'd0);
        chk("mid_reset_alu_valid", 64'(alu_valid), 64'd0);
        chk("mid_reset_ls_valid", 64'(ls_valid), 64'd0);
        chk("mid_reset_vac_alu", 64'(ib_vacant_ALU), 64'd1);
        chk("mid_reset_vac_ls", 64'(ib_vacant_LS), 64'd1);
        chk("mid_reset_iss_imm", 64'(iss_imm), 64'd0);
        tick();
        wb(5'd9, 3'd4);
        alu_ready = 1'b1;
        push(1'b0, OPT_BRANCH, 5'd0, 5'd9, 5'd9, 32'h77);
        @(negedge clk);
        chk("reg9_free", 64'(alu_valid), 64'd1);
        wait_drain("drain_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- In-order issue scheduler between i_buffer and the execution units; occupies the sb_* side of i_buffer (sb_vacant_ALU/LS, sb_valid, ...).
- Queues decoded instructions in a circular buffer and tracks per-register pending writes.
- Issues the head instruction to the ALU or LS unit once RAW/WAW hazards clear, and releases registers on the wb broadcast.

Parameters:
SB_SIZE, 8, queue depth (power of 2; tag width `SB_SIZE_WID = log2(SB_SIZE))
ALU_MAX, 6, max queued ALU-class entries
LS_MAX, 4, max queued LS-class entries
NREG, 32, architectural vector registers (indexed by `REG_WID)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
ib_vacant_ALU  out  1  an ALU-class instruction can be accepted this cycle
ib_vacant_LS  out  1  an LS-class instruction can be accepted this cycle
ib_valid  in  1  instruction presented; only asserted when the matching vacant is high
ib_opt  in  `OPT_WID  opcode class
ib_funct  in  `FUNCT3_WID  funct3
ib_rs1, ib_rs2, ib_rd  in  `REG_WID each  register fields
ib_imm  in  `XLEN  immediate
alu_ready  in  1  ALU can take an instruction
ls_ready  in  1  LS unit can take an instruction
alu_valid  out  1  issue to ALU
ls_valid  out  1  issue to LS
iss_opt, iss_funct, iss_rs1, iss_rs2, iss_rd, iss_imm  out  as ib_*  shared issue bus
iss_pos  out  `SB_SIZE_WID  tag of the issued entry; the unit returns it on wb_pos
wb_valid  in  1  write-back broadcast
wb_pos  in  `SB_SIZE_WID  tag of the completing instruction
wb_rd  in  `REG_WID  destination register being written

Behaviour:
- Reset (rst==0 at a posedge): head = tail = count = 0; alu_cnt = ls_cnt = 0; reg_busy[*] = 0; reg_pos[*] = 0.
  - After reset: ib_vacant_ALU = ib_vacant_LS = 1; alu_valid = ls_valid = 0; iss_* = 0.
  - A reset mid-operation discards all queued entries and pending-register state; in-flight wb broadcasts after reset are ignored.
- Vacancy (from registered state only):
  - ib_vacant_ALU = (count < SB_SIZE) && (alu_cnt < ALU_MAX).
  - ib_vacant_LS = (count < SB_SIZE) && (ls_cnt < LS_MAX).
  - A same-cycle issue does not raise vacancy.
- Accept: on ib_valid, write the entry at tail; tail+1 (mod SB_SIZE); count+1; increment the class counter.
  - Class comes from the package functions is_ls(opt) and has_rd(opt).
  - Earliest issue of an accepted entry is the next cycle.
- Head issue check (combinational, head entry only):
  - RAW stall if a used source rsX has busy_eff[rsX].
  - WAW stall if has_rd and busy_eff[rd].
  - busy_eff = reg_busy with this cycle's wb_rd cleared (wb bypass).
- Issue:
  - If count>0 and no stall, assert alu_valid (ALU class) or ls_valid (LS class).
  - iss_* = head fields; iss_pos = head index.
  - Once asserted, valid stays high with a stable bus until ready.
  - On valid&&ready: head+1, count-1, class counter-1.
  - If has_rd: reg_busy[rd] = 1, reg_pos[rd] = head.
  - At most one issue per cycle; strictly in order across both classes (an LS head blocks a ready ALU entry behind it).
- Write-back: on wb_valid, reg_busy[wb_rd] = 0.
  - If wb_pos != reg_pos[wb_rd], flag a simulation-only error.
  - Only has_rd instructions broadcast.
  - Same-cycle issue setting rd and wb clearing the same rd: the set wins.
- Simultaneous accept and issue: count, alu_cnt and ls_cnt are net-updated (may stay equal).
  - Full queue plus issue in the same cycle: accept is still refused (vacancy was 0).
- Pointer wrap: head and tail wrap from SB_SIZE-1 to 0; count disambiguates full from empty.

Decomposition:
- Shared package/macros: SB_SIZE, `SB_SIZE_WID, class encodings, is_ls(opt), has_rd(opt), and the entry-field width macros already used by i_buffer.
- One sub-module, sb_reg_status: NREG-entry busy/pos table with set port (issue) and clear port (wb), plus combinational busy_eff lookups for rs1/rs2/rd.

Test Plan:
- Reset then 3 independent ALU ops (rd=1,2,3), alu_ready=1 -> issued on consecutive cycles, iss_pos 0,1,2; reg_busy bits 1–3 set until wb arrives.
- ALU rd=5, then ALU rs1=5 -> second op held with alu_valid=0; wb_valid with wb_rd=5 -> second op issues that same cycle (bypass).
- Fill 6 ALU ops with alu_ready=0 -> ib_vacant_ALU=0 and ib_vacant_LS=1; 2 LS ops -> count=8, both vacancies 0; one ALU issue -> ib_vacant_LS=1, ib_vacant_ALU=1 next cycle.
- LS load rd=4 in flight, then ALU rd=4 -> WAW stall until wb_rd=4; an ALU rd=7 queued behind is not issued before it (in-order).
- 20 accept/issue pairs with alu_ready toggling every cycle -> tags wrap 7->0, no entry lost or duplicated, count never exceeds 8.
- Reset asserted with 5 entries queued and reg_busy[9]=1 -> next cycle count=0, alu_valid=ls_valid=0, both vacancies 1, reg 9 not busy.
